// File: rtl/dlsc_mt9v032_serializer_if.sv
// Pixel stream handshake into the MT9V032 serializer.
// The pixel source uses master; the serializer uses slave.
interface dlsc_mt9v032_serializer_if;
  logic       px_ready;
  logic       px_valid;
  logic [9:0] px_data;

  modport master (input px_ready, output px_valid, output px_data);
  modport slave  (output px_ready, input px_valid, input px_data);
endinterface

// File: rtl/dlsc_mt9v032_serializer.sv
// MT9V032-format serializer.
// Each 10-bit code goes out MSB first as a 12-bit word {1, d[9:0], 0}, one bit per clk.
// The stream carries embedded sync words, horizontal blanking and vertical blanking.
// state/word/line describe the word currently on ser_out.
// They advance only at a word boundary: bit 11 of a word, or any cycle while IDLE.
module dlsc_mt9v032_serializer #(
  parameter int HDISP  = 752,
  parameter int VDISP  = 480,
  parameter int HBLANK = 94,
  parameter int VBLANK = 45
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
  dlsc_mt9v032_serializer_if.slave        px,
  output logic                            ser_out,
  output logic                            frame_start,
  output logic                            line_start,
  output logic                            underrun,
  input  logic                            underrun_clr
);

  localparam int LINE_WORDS  = 2 + HDISP + HBLANK;
  localparam int FRAME_LINES = VDISP + VBLANK;
  localparam int WCW         = $clog2(LINE_WORDS);
  localparam int LCW         = $clog2(FRAME_LINES);

  localparam logic [WCW-1:0] W_SYNC_END = WCW'(1);
  localparam logic [WCW-1:0] W_ACT_END  = WCW'(HDISP + 1);
  localparam logic [WCW-1:0] W_LAST     = WCW'(LINE_WORDS - 1);
  localparam logic [LCW-1:0] L_ACT_END  = LCW'(VDISP - 1);
  localparam logic [LCW-1:0] L_LAST     = LCW'(FRAME_LINES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_ACTIVE,
    ST_HBLANK,
    ST_VBLANK
  } state_t;

  state_t         state_reg, state_next;
  logic [3:0]     bit_cnt_reg;
  logic [WCW-1:0] word_cnt_reg, word_next;
  logic [LCW-1:0] line_cnt_reg, line_next;
  logic [10:0]    shift_reg;
  logic           boundary;
  logic           ready_int;
  logic           underrun_set;
  logic [9:0]     data_next;

  assign px.px_ready  = ready_int;
  assign underrun_set = ready_int & ~px.px_valid;

  // Next-word sequencing, pixel-slot detection and next word contents.
  always_comb begin
    state_next = state_reg;
    word_next  = word_cnt_reg;
    line_next  = line_cnt_reg;
    data_next  = 10'h000;
    boundary   = (state_reg == ST_IDLE) || (bit_cnt_reg == 4'd11);

    if (boundary) begin
      case (state_reg)
        ST_IDLE: begin
          if (enable) begin
            state_next = ST_SYNC;
            word_next  = '0;
            line_next  = '0;
          end
        end
        ST_SYNC: begin
          word_next = word_cnt_reg + 1'b1;
          if (word_cnt_reg == W_SYNC_END) state_next = ST_ACTIVE;
        end
        ST_ACTIVE: begin
          word_next = word_cnt_reg + 1'b1;
          if (word_cnt_reg == W_ACT_END) state_next = ST_HBLANK;
        end
        ST_HBLANK: begin
          if (word_cnt_reg == W_LAST) begin
            word_next  = '0;
            line_next  = line_cnt_reg + 1'b1;
            state_next = (line_cnt_reg == L_ACT_END) ? ST_VBLANK : ST_SYNC;
          end else begin
            word_next = word_cnt_reg + 1'b1;
          end
        end
        ST_VBLANK: begin
          if (word_cnt_reg == W_LAST) begin
            word_next = '0;
            if (line_cnt_reg == L_LAST) begin
              // enable is only consulted here and in IDLE, so frames never truncate
              line_next  = '0;
              state_next = enable ? ST_SYNC : ST_IDLE;
            end else begin
              line_next = line_cnt_reg + 1'b1;
            end
          end else begin
            word_next = word_cnt_reg + 1'b1;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end

    // Only ACTIVE is entered from SYNC/ACTIVE, so this depends on position alone
    ready_int = (state_reg != ST_IDLE) && (bit_cnt_reg == 4'd11) && (state_next == ST_ACTIVE);

    case (state_next)
      ST_SYNC:   data_next = (word_next == '0 || line_next == '0) ? 10'h3FF : 10'h000;
      ST_ACTIVE: begin
        // Reserved codes 0x000/0x3FF never appear in pixel slots
        if (!px.px_valid || px.px_data == 10'h000) data_next = 10'h001;
        else if (px.px_data == 10'h3FF)           data_next = 10'h3FE;
        else                                      data_next = px.px_data;
      end
      default:   data_next = 10'h000;
    endcase
  end

  // Frame position registers: state, word-in-line and line-in-frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      word_cnt_reg <= '0;
      line_cnt_reg <= '0;
    end else if (boundary) begin
      state_reg    <= state_next;
      word_cnt_reg <= word_next;
      line_cnt_reg <= line_next;
    end
  end

  // Bit shifter, sync pulses and sticky underrun flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      ser_out     <= 1'b0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      underrun    <= underrun_set | (underrun & ~underrun_clr);
      if (boundary) begin
        bit_cnt_reg <= '0;
        if (state_next == ST_IDLE) begin
          ser_out   <= 1'b0;
          shift_reg <= '0;
        end else begin
          // Start bit goes out now; the remaining 11 bits wait in the shifter
          ser_out     <= 1'b1;
          shift_reg   <= {data_next, 1'b0};
          line_start  <= (state_next == ST_SYNC) && (word_next == '0);
          frame_start <= (state_next == ST_SYNC) && (word_next == '0) && (line_next == '0);
        end
      end else begin
        bit_cnt_reg <= bit_cnt_reg + 1'b1;
        ser_out     <= shift_reg[10];
        shift_reg   <= {shift_reg[9:0], 1'b0};
      end
    end
  end

endmodule
